// File: rtl/pc_sequencer_pkg.sv
// Shared processor definitions: sequencer state encoding and address defaults.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_IN = 2'd1,
        ST_HALTED  = 2'd2
    } seq_state_e;

    localparam logic [31:0] INT_VECTOR_DEF = 32'd16;
    localparam logic [31:0] RESET_PC_DEF   = 32'd0;

    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus1,
                                                  input logic [15:0] offset);
        return pc_plus1 + {{16{offset[15]}}, offset};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control, branch, timer and status signals between the decode stage and the PC sequencer.
interface pc_sequencer_if;
    logic        PCFunct;
    logic        EnableClock;
    logic        Button;
    logic        BEQ;
    logic        BNE;
    logic        Zero;
    logic        ControlJump;
    logic        JumpReg;
    logic [25:0] JumpTarget;
    logic [15:0] BranchOffset;
    logic [31:0] RegTarget;
    logic        setClock;
    logic [31:0] SetValue;
    logic        getInterruption;
    logic [31:0] PC;
    logic [31:0] PCPlus1;
    logic [31:0] PCBuffer;
    logic        Interrupt;
    logic        Halted;
    logic        WaitingInput;

    modport master (
        output PCFunct, EnableClock, Button, BEQ, BNE, Zero, ControlJump, JumpReg,
               JumpTarget, BranchOffset, RegTarget, setClock, SetValue, getInterruption,
        input  PC, PCPlus1, PCBuffer, Interrupt, Halted, WaitingInput
    );

    modport slave (
        input  PCFunct, EnableClock, Button, BEQ, BNE, Zero, ControlJump, JumpReg,
               JumpTarget, BranchOffset, RegTarget, setClock, SetValue, getInterruption,
        output PC, PCPlus1, PCBuffer, Interrupt, Halted, WaitingInput
    );
endinterface

// File: rtl/pc_sequencer_button_sync_edge.sv
// Two-flop synchronizer for the asynchronous Button, plus a one-cycle rising-edge pulse.
module button_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic button_rise
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = button_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign button_rise = sync2_q & ~prev_q;
endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: next-PC selection, halt / IN-stall FSM, and a quantum timer
// that raises a single-level interrupt.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = INT_VECTOR_DEF,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
    input  logic          clock,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_buf_q, pc_buf_d;
    logic [31:0] timer_q, timer_d;
    logic        pending_q, pending_d;
    logic        int_q, int_d;
    logic        halted_q, halted_d;
    logic        waiting_q, waiting_d;

    logic        btn_rise;
    logic [31:0] pc_plus1;
    logic [31:0] next_seq;
    logic        branch_taken;
    logic        advance;
    logic        take_int;

    button_sync_edge u_button_sync_edge (
        .clock      (clock),
        .reset      (reset),
        .button_in  (bus.Button),
        .button_rise(btn_rise)
    );

    always_comb begin
        pc_plus1     = pc_q + 32'd1;
        branch_taken = (bus.BEQ & bus.Zero) | (bus.BNE & ~bus.Zero);
        if (bus.JumpReg)
            next_seq = bus.RegTarget;
        else if (bus.ControlJump)
            next_seq = {pc_plus1[31:26], bus.JumpTarget};
        else if (branch_taken)
            next_seq = branch_target(pc_plus1, bus.BranchOffset);
        else
            next_seq = pc_plus1;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_buf_d  = pc_buf_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        int_d     = int_q;
        halted_d  = halted_q;
        waiting_d = waiting_q;
        advance   = 1'b0;

        // Halt outranks the IN stall; HALTED is left only through reset.
        unique case (state_q)
            ST_RUN: begin
                if (!bus.PCFunct) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (!bus.EnableClock) begin
                    state_d   = ST_WAIT_IN;
                    waiting_d = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_WAIT_IN: begin
                if (!bus.PCFunct) begin
                    state_d   = ST_HALTED;
                    halted_d  = 1'b1;
                    waiting_d = 1'b0;
                end else if (btn_rise) begin
                    state_d   = ST_RUN;
                    waiting_d = 1'b0;
                    advance   = 1'b1;
                end
            end
            default: ;
        endcase

        // Entry only from a RUN cycle that moves the PC, and never while an interrupt is live.
        take_int = advance && (state_q == ST_RUN) && pending_q && !int_q;

        if (bus.getInterruption)
            int_d = 1'b0;

        if (take_int) begin
            pc_d      = INT_VECTOR;
            pc_buf_d  = next_seq;
            int_d     = 1'b1;
            pending_d = 1'b0;
        end else if (advance) begin
            pc_d = next_seq;
        end

        if (bus.setClock) begin
            timer_d   = bus.SetValue;
            pending_d = 1'b0;
        end else if ((state_q == ST_RUN) && (timer_q != 32'd0)) begin
            timer_d = timer_q - 32'd1;
            if (timer_q == 32'd1)
                pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            pc_buf_q  <= 32'd0;
            timer_q   <= 32'd0;
            pending_q <= 1'b0;
            int_q     <= 1'b0;
            halted_q  <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_buf_q  <= pc_buf_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            int_q     <= int_d;
            halted_q  <= halted_d;
            waiting_q <= waiting_d;
        end
    end

    assign bus.PC           = pc_q;
    assign bus.PCPlus1      = pc_plus1;
    assign bus.PCBuffer     = pc_buf_q;
    assign bus.Interrupt    = int_q;
    assign bus.Halted       = halted_q;
    assign bus.WaitingInput = waiting_q;
endmodule
